// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The NOP word is built from the NOP opcode so the CPU decodes it as a no-operation.
package imem_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StRun,
        StWait
    } imem_state_e;

    localparam logic [5:0]  OPCODE_NOP  = 6'h00;
    localparam logic [31:0] NOP_DEFAULT = {OPCODE_NOP, 26'h0};

    // Wide enough for WAIT_STATES up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: async clear to NOP_WORD, one write port and
// one registered read port that only updates on rd_en.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 64,
    parameter int unsigned       AW       = 6,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data is held between fetches so the top can present it until the next ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= NOP_WORD;
        end else if (rd_en) begin
            rd_data <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : NOP_WORD;
        end
    end

endmodule

// File: rtl/imem_prog_fetch.sv
// Loadable instruction memory with a req/ack fetch port and configurable wait states.
// Words are loaded until prog_last; fetches at or beyond prog_len return NOP_WORD with a fault.
module imem_prog_fetch
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(NOP_DEFAULT),
    localparam int unsigned      AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned      LW          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    input  logic              prog_restart,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault,
    output logic              loaded,
    output logic [LW-1:0]     prog_len
);

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LW-1:0]     len_q, len_d;
    logic              ack_q, ack_d;
    logic              fault_q, fault_d;
    logic              wr_en, rd_en, in_range;
    logic [LW-1:0]     addr_p1;
    logic [DATA_W-1:0] rd_data;

    assign in_range = 32'(prog_addr) < DEPTH;
    assign addr_p1  = LW'(32'(prog_addr) + 32'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        len_d   = len_q;
        ack_d   = 1'b0;
        fault_d = fault_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        // Restart wins over any same-cycle write or fetch and aborts an in-flight fetch.
        if (prog_restart) begin
            state_d = StLoad;
            len_d   = '0;
        end else begin
            case (state_q)
                StEmpty, StLoad: begin
                    if (prog_valid) begin
                        if (in_range) begin
                            wr_en = 1'b1;
                            if (addr_p1 > len_q) len_d = addr_p1;
                        end
                        state_d = prog_last ? StRun : StLoad;
                    end
                end
                StRun: begin
                    if (fetch_req) begin
                        state_d = StWait;
                        pc_d    = fetch_pc;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                        ack_d   = 1'b1;
                        rd_en   = 1'b1;
                        // Full-width compare: a large pc must never alias into the program.
                        fault_d = pc_q >= ADDR_W'(len_q);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
        end
    end

    imem_array #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NOP_WORD (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (rd_en),
        .rd_addr (pc_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign prog_ready  = (state_q == StEmpty) || (state_q == StLoad);
    assign loaded      = (state_q == StRun) || (state_q == StWait);
    assign fetch_ack   = ack_q;
    assign fetch_fault = fault_q;
    assign fetch_instr = fault_q ? NOP_WORD : rd_data;
    assign prog_len    = len_q;

endmodule
